// File: rtl/prog_clock_div_multi.sv
// Multi-channel run-time programmable clock divider.
// Each channel counts 0..D-1 and produces a 50% square wave (even or odd D)
// or a single-cycle pulse, plus a start-of-period tick. New divisor/mode
// values wait in a pending register and are applied only at a period
// boundary (wrap, start or disable edge), so the output never glitches.
//
// Per-channel state:
//   state    | meaning
//   ST_IDLE  | channel disabled, counter held at 0, outputs low
//   ST_RUN   | channel counting 0..D-1, outputs follow the active mode
module prog_clock_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clock_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH*DIV_W-1:0] div_val_i,
  input  logic [NUM_CH-1:0]       div_mode_i,
  input  logic [NUM_CH-1:0]       div_load_i,
  input  logic [NUM_CH-1:0]       enable_i,
  output logic [NUM_CH-1:0]       out_clock_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       div_busy_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             mode_q, mode_d;
    logic             pend_mode_q, pend_mode_d;
    logic             busy_q, busy_d;
    logic             p_q, p_d;
    logic             tick_q, tick_d;
    logic             n_q;
    logic             boundary;
    logic [DIV_W-1:0] thr;
    logic [DIV_W-1:0] load_val;
    logic [DIV_W-1:0] load_clamped;
    logic             en;
    logic             load;

    assign en           = enable_i[gi];
    assign load         = div_load_i[gi];
    assign load_val     = div_val_i[gi*DIV_W +: DIV_W];
    // 0 and 1 are meaningless divisors; the smallest legal period is 2.
    assign load_clamped = (load_val < DIV_MIN) ? DIV_MIN : load_val;

    // Next-state: counter/FSM, boundary detection, pending apply, output terms.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      mode_d      = mode_q;
      pend_div_d  = pend_div_q;
      pend_mode_d = pend_mode_q;
      busy_d      = busy_q;
      p_d         = 1'b0;
      tick_d      = 1'b0;
      boundary    = 1'b0;
      thr         = '0;

      case (state_q)
        ST_IDLE: begin
          // Every idle edge is a boundary: either a start or a disable edge.
          boundary = 1'b1;
          cnt_d    = '0;
          if (en) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            boundary = 1'b1;
          end else if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      // The old pending value is applied before a same-edge load replaces it.
      if (boundary && busy_q) begin
        div_d  = pend_div_q;
        mode_d = pend_mode_q;
      end

      if (load) begin
        pend_div_d  = load_clamped;
        pend_mode_d = div_mode_i[gi];
        busy_d      = 1'b1;
      end else if (boundary) begin
        busy_d = 1'b0;
      end

      // High-phase length: D/2 for even D, (D+1)/2 for odd D; the odd case
      // is trimmed by half a cycle through the negedge retime flop.
      thr = (div_d >> 1) + {{(DIV_W-1){1'b0}}, div_d[0]};

      if (state_d == ST_RUN) begin
        tick_d = (cnt_d == '0);
        if (mode_d) begin
          p_d = (cnt_d == '0);
        end else begin
          p_d = (cnt_d < thr);
        end
      end
    end

    // Posedge state register with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q     <= ST_IDLE;
        cnt_q       <= '0;
        div_q       <= DIV_RST;
        mode_q      <= 1'b0;
        pend_div_q  <= '0;
        pend_mode_q <= 1'b0;
        busy_q      <= 1'b0;
        p_q         <= 1'b0;
        tick_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        div_q       <= div_d;
        mode_q      <= mode_d;
        pend_div_q  <= pend_div_d;
        pend_mode_q <= pend_mode_d;
        busy_q      <= busy_d;
        p_q         <= p_d;
        tick_q      <= tick_d;
      end
    end

    // Negedge retime of the square term, used to delay the rising edge by
    // half a clock for odd divisors.
    always_ff @(negedge clock_i or negedge rst_ni) begin
      if (!rst_ni) begin
        n_q <= 1'b0;
      end else begin
        n_q <= p_q;
      end
    end

    assign out_clock_o[gi] = (!mode_q && div_q[0]) ? (p_q & n_q) : p_q;
    assign tick_o[gi]      = tick_q;
    assign div_busy_o[gi]  = busy_q;
  end

endmodule

// File: tb/tb_prog_clock_div_multi.sv
// Bench for prog_clock_div_multi: directed scenarios plus random traffic,
// checked by a queue-based scoreboard against a half-cycle reference model.
module tb_prog_clock_div_multi;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 2;

  logic                    clock = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_val = '0;
  logic [NUM_CH-1:0]       div_mode = '0;
  logic [NUM_CH-1:0]       div_load = '0;
  logic [NUM_CH-1:0]       enable = '0;
  logic [NUM_CH-1:0]       out_clock;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       div_busy;

  prog_clock_div_multi #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clock_i(clock),
    .rst_ni(rst_n),
    .div_val_i(div_val),
    .div_mode_i(div_mode),
    .div_load_i(div_load),
    .enable_i(enable),
    .out_clock_o(out_clock),
    .tick_o(tick),
    .div_busy_o(div_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NUM_CH-1:0] out;
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] busy;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: position k within the current period, active and
  // pending divisor/mode, run flag.
  int m_k  [NUM_CH];
  int m_d  [NUM_CH];
  int m_pd [NUM_CH];
  bit m_run[NUM_CH];
  bit m_mode[NUM_CH];
  bit m_pmode[NUM_CH];
  bit m_busy[NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_k[c] = 0; m_d[c] = DEFAULT_DIV; m_pd[c] = 0;
      m_run[c] = 0; m_mode[c] = 0; m_pmode[c] = 0; m_busy[c] = 0;
    end
  endfunction

  function automatic int clamp_div(int v);
    return (v < 2) ? 2 : v;
  endfunction

  // One rising edge of the system clock, applied to the model.
  function automatic void model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit bnd;
      bnd = 0;
      if (!enable[c]) begin
        m_run[c] = 0; m_k[c] = 0; bnd = 1;
      end else if (!m_run[c]) begin
        m_run[c] = 1; m_k[c] = 0; bnd = 1;
      end else if (m_k[c] == m_d[c] - 1) begin
        m_k[c] = 0; bnd = 1;
      end else begin
        m_k[c] = m_k[c] + 1;
      end
      if (bnd && m_busy[c]) begin
        m_d[c] = m_pd[c]; m_mode[c] = m_pmode[c];
      end
      if (div_load[c]) begin
        m_pd[c] = clamp_div(int'(div_val[c*DIV_W +: DIV_W]));
        m_pmode[c] = div_mode[c];
        m_busy[c] = 1;
      end else if (bnd) begin
        m_busy[c] = 0;
      end
    end
  endfunction

  // Expected outputs in a half cycle; h counts half periods since the period
  // started. Square is high for h in [0,D) when D is even and [1,D] when odd.
  function automatic exp_t model_exp(bit neg);
    exp_t e;
    int   h;
    int   odd;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e.busy[c] = m_busy[c];
      if (m_run[c]) begin
        h   = 2 * m_k[c] + int'(neg);
        odd = m_d[c] % 2;
        e.tk[c] = (m_k[c] == 0);
        if (m_mode[c]) e.out[c] = (m_k[c] == 0);
        else           e.out[c] = (h >= odd) && (h < m_d[c] + odd);
      end
    end
    return e;
  endfunction

  // Advance one clock: model the edge, queue the two half-cycle expectations,
  // and return at negedge+2 where inputs may be changed safely.
  task automatic step();
    @(posedge clock);
    model_edge();
    sb_q.push_back(model_exp(1'b0));
    sb_q.push_back(model_exp(1'b1));
    @(negedge clock);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_ch(input int c, input int val, input bit mode);
    div_val[c*DIV_W +: DIV_W] = val[DIV_W-1:0];
    div_mode[c] = mode;
    div_load[c] = 1'b1;
    step();
    div_load[c] = 1'b0;
  endtask

  task automatic wait_state(input int c, input int d, input int k);
    int i;
    i = 0;
    while (i < 400 && !(m_run[c] && m_d[c] == d && m_k[c] == k)) begin
      step();
      i++;
    end
    checks++;
    if (!(m_run[c] && m_d[c] == d && m_k[c] == k)) begin
      failures++;
      $display("FAIL wait_state ch%0d: model d=%0d k=%0d, required d=%0d k=%0d", c, m_d[c], m_k[c], d, k);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({out_clock, tick, div_busy} !== '0) begin
      failures++;
      $display("FAIL %s t=%0t: out=%b tick=%b busy=%b, required all 0", name, $time, out_clock, tick, div_busy);
    end
  endtask

  task automatic mon_check();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({out_clock, tick, div_busy} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t: out=%b tick=%b busy=%b, required out=%b tick=%b busy=%b",
                 $time, out_clock, tick, div_busy, e.out, e.tk, e.busy);
      end
    end
  endtask

  // Monitor: compares DUT outputs 1 time unit after each clock edge.
  initial begin
    forever begin
      @(posedge clock); #1; mon_check();
      @(negedge clock); #1; mon_check();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    #2;
    check_zero("reset_state");
    rst_n = 1'b1;

    // T1: default divisor 2 on channel 0
    enable[0] = 1'b1;
    steps(8);

    // T2: ch1 D=6 square, enabled right after the load
    load_ch(1, 6, 1'b0);
    enable[1] = 1'b1;
    steps(14);

    // T3: ch2 D=5 square (odd, half-cycle high phase)
    load_ch(2, 5, 1'b0);
    enable[2] = 1'b1;
    steps(12);

    // T4: ch3 D=100 pulse
    load_ch(3, 100, 1'b1);
    enable[3] = 1'b1;
    steps(210);

    // T5: ch0 running D=10, load D=4 on the edge where cnt becomes 3
    load_ch(0, 10, 1'b0);
    wait_state(0, 10, 2);
    load_ch(0, 4, 1'b0);
    steps(20);

    // Load coinciding with a wrap while another value is pending
    wait_state(1, 6, 2);
    load_ch(1, 4, 1'b0);
    wait_state(1, 6, 5);
    load_ch(1, 3, 1'b0);
    steps(20);

    // T6: clamping of 0/1, then asynchronous reset mid-period
    load_ch(2, 1, 1'b0);
    load_ch(3, 0, 1'b1);
    steps(12);
    wait_state(0, 4, 0);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clock); #1;
    check_zero("reset_hold");
    @(negedge clock); #2;
    rst_n = 1'b1;
    steps(10);

    // Random traffic: loads of small/large divisors, modes, enable drops
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        enable[c] = ($urandom_range(0, 24) != 0);
        if ($urandom_range(0, 11) == 0) begin
          div_val[c*DIV_W +: DIV_W] = ($urandom_range(0, 9) == 0) ?
                                      DIV_W'($urandom_range(13, 40)) :
                                      DIV_W'($urandom_range(0, 12));
          div_mode[c] = 1'($urandom_range(0, 1));
          div_load[c] = 1'b1;
        end else begin
          div_load[c] = 1'b0;
        end
      end
      step();
    end
    div_load = '0;
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
